// File: rtl/div_pkg.sv
// Shared types for the repeated-subtraction divider.
// FSM state encoding and datapath control bundle.
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LDB  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic sub;
    logic zdiv;
  } div_ctrl_t;

  function automatic logic is_busy(div_state_e s);
    return (s == LDB) || (s == CALC);
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: operand, quotient and remainder registers.
// Status flags feed the controller in the top level.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  div_ctrl_t        ctrl_i,
  output logic             r_ge_b_o,
  output logic             b_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] r_sub;
  logic [WIDTH-1:0] q_inc;

  assign r_sub    = r_q - b_q;
  assign q_inc    = q_q + WIDTH'(1);
  assign r_ge_b_o = (r_q >= b_q);
  assign b_zero_o = (b_q == '0);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    q_d   = q_q;
    r_d   = r_q;
    dbz_d = dbz_q;
    unique case (1'b1)
      ctrl_i.load_a: begin
        a_d   = data_i;
        dbz_d = 1'b0;
      end
      ctrl_i.load_b: begin
        b_d = data_i;
        r_d = a_q;
        q_d = '0;
      end
      ctrl_i.zdiv: begin
        q_d   = '1;
        dbz_d = 1'b1;
      end
      ctrl_i.sub: begin
        r_d = r_sub;
        q_d = q_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient_o  = q_q;
  assign remainder_o = r_q;
  assign dbz_o       = dbz_q;

endmodule

// File: rtl/div_repeated_sub.sv
// Unsigned divider by repeated subtraction, one step per clock.
// Controller FSM here; registers and arithmetic in div_datapath.
module div_repeated_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e state_q, state_d;
  div_ctrl_t  ctrl;
  logic       r_ge_b;
  logic       b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // B==0 wins over R>=B, which would otherwise loop forever
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = LDB;
      end
      LDB: state_d = CALC;
      CALC: begin
        if (b_zero)      state_d = DONE;
        else if (!r_ge_b) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      IDLE, DONE: ctrl.load_a = start;
      LDB:        ctrl.load_b = 1'b1;
      CALC: begin
        if (b_zero)      ctrl.zdiv = 1'b1;
        else if (r_ge_b) ctrl.sub  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = is_busy(state_q);
  assign done = (state_q == DONE);

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_in),
    .ctrl_i     (ctrl),
    .r_ge_b_o   (r_ge_b),
    .b_zero_o   (b_zero),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .dbz_o      (div_by_zero)
  );

endmodule
